// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared PIC types, widths and OCW2 EOI command encodings
package pic_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK1 = 1'b1
  } pic_state_e;

  localparam int PIC_NUM_IRQ_DEFAULT = 8;

  // A single-bit index is still needed for the two-channel case.
  function automatic int idx_width(input int num_irq);
    return (num_irq <= 2) ? 1 : $clog2(num_irq);
  endfunction

  function automatic int spurious_idx(input int num_irq);
    return num_irq - 1;
  endfunction

  localparam int SPURIOUS_IDX = PIC_NUM_IRQ_DEFAULT - 1;

  // OCW2 {R, SL, EOI} field values decoded upstream into eoiValid/eoiSpecific/eoiRotate.
  localparam logic [2:0] EOI_CMD_NONSPECIFIC     = 3'b001;
  localparam logic [2:0] EOI_CMD_SPECIFIC        = 3'b011;
  localparam logic [2:0] EOI_CMD_ROT_NONSPECIFIC = 3'b101;
  localparam logic [2:0] EOI_CMD_ROT_SPECIFIC    = 3'b111;
  localparam logic [2:0] EOI_CMD_ROT_AEOI_SET    = 3'b100;
  localparam logic [2:0] EOI_CMD_ROT_AEOI_CLR    = 3'b000;

endpackage

// File: rtl/rotating_priority_scan.sv
// rtl/rotating_priority_scan.sv - find-first-set starting one above the lowest-priority channel
module rotating_priority_scan
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  localparam int IDX_W   = idx_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [IDX_W-1:0]   lowest,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest set bit is the last writer.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      cand = lowest + IDX_W'(1) + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/isr_rotating_controller.sv
// rtl/isr_rotating_controller.sv - in-service register, INTA sequencer, EOI/AEOI and rotation
module isr_rotating_controller
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  parameter  int VEC_W   = 8,
  localparam int IDX_W   = idx_width(NUM_IRQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   intReq,
  input  logic [IDX_W-1:0]       intReqIndex,
  input  logic                   intaPulse,
  input  logic [VEC_W-IDX_W-1:0] vectorBase,
  input  logic                   autoEoi,
  input  logic                   eoiValid,
  input  logic                   eoiSpecific,
  input  logic [IDX_W-1:0]       eoiIndex,
  input  logic                   eoiRotate,
  input  logic                   readIsr,
  output logic [NUM_IRQ-1:0]     isrValue,
  output logic [IDX_W-1:0]       lowestPrio,
  output logic [VEC_W-1:0]       dataOut,
  output logic                   dataOutValid,
  output logic [IDX_W-1:0]       resetedIndex,
  output logic                   resetedValid,
  output logic                   busy
);

  localparam logic [IDX_W-1:0] SPUR_IDX = IDX_W'(spurious_idx(NUM_IRQ));

  pic_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               spur_q, spur_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [IDX_W-1:0]   lowest_q, lowest_d;
  logic [VEC_W-1:0]   data_q, data_d;
  logic               data_valid_q, data_valid_d;
  logic [IDX_W-1:0]   reseted_idx_q, reseted_idx_d;
  logic               reseted_valid_q, reseted_valid_d;
  logic               busy_q, busy_d;

  logic [NUM_IRQ-1:0] set_mask;
  logic [NUM_IRQ-1:0] clr_mask;
  logic               aeoi_fire;
  logic               vec_drive;
  logic               scan_found;
  logic [IDX_W-1:0]   scan_idx;

  rotating_priority_scan #(
    .NUM_IRQ (NUM_IRQ)
  ) u_scan (
    .req    (isr_q),
    .lowest (lowest_q),
    .found  (scan_found),
    .index  (scan_idx)
  );

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    spur_d          = spur_q;
    lowest_d        = lowest_q;
    data_d          = data_q;
    data_valid_d    = 1'b0;
    reseted_idx_d   = reseted_idx_q;
    reseted_valid_d = 1'b0;
    busy_d          = busy_q;
    set_mask        = '0;
    clr_mask        = '0;
    aeoi_fire       = 1'b0;
    vec_drive       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (intaPulse) begin
          state_d = ST_ACK1;
          busy_d  = 1'b1;
          if (intReq) begin
            idx_d                 = intReqIndex;
            spur_d                = 1'b0;
            set_mask[intReqIndex] = 1'b1;
          end else begin
            idx_d  = SPUR_IDX;
            spur_d = 1'b1;
          end
        end
      end
      ST_ACK1: begin
        if (intaPulse) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          vec_drive = 1'b1;
          data_d    = {vectorBase, idx_q};
          if (autoEoi && !spur_q) begin
            aeoi_fire         = 1'b1;
            clr_mask[idx_q]   = 1'b1;
            reseted_idx_d     = idx_q;
            reseted_valid_d   = 1'b1;
            if (eoiRotate) begin
              lowest_d = idx_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An automatic EOI on this edge owns the clear and rotation; a command EOI is dropped.
    if (eoiValid && !aeoi_fire) begin
      if (eoiSpecific) begin
        if (isr_q[eoiIndex]) begin
          clr_mask[eoiIndex] = 1'b1;
          reseted_idx_d      = eoiIndex;
          reseted_valid_d    = 1'b1;
        end
        if (eoiRotate) begin
          lowest_d = eoiIndex;
        end
      end else if (scan_found) begin
        clr_mask[scan_idx] = 1'b1;
        reseted_idx_d      = scan_idx;
        reseted_valid_d    = 1'b1;
        if (eoiRotate) begin
          lowest_d = scan_idx;
        end
      end
    end

    if (vec_drive) begin
      data_valid_d = 1'b1;
    end else if (readIsr) begin
      data_d       = VEC_W'(isr_q);
      data_valid_d = 1'b1;
    end

    isr_d = (isr_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      spur_q          <= 1'b0;
      isr_q           <= '0;
      lowest_q        <= SPUR_IDX;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      reseted_idx_q   <= '0;
      reseted_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      spur_q          <= spur_d;
      isr_q           <= isr_d;
      lowest_q        <= lowest_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      reseted_idx_q   <= reseted_idx_d;
      reseted_valid_q <= reseted_valid_d;
      busy_q          <= busy_d;
    end
  end

  assign isrValue     = isr_q;
  assign lowestPrio   = lowest_q;
  assign dataOut      = data_q;
  assign dataOutValid = data_valid_q;
  assign resetedIndex = reseted_idx_q;
  assign resetedValid = reseted_valid_q;
  assign busy         = busy_q;

endmodule

// File: doc/isr_rotating_controller.md
Name: isr_rotating_controller

Overview:
Parametrised in-service register for the PIC core. It tracks in-service interrupts across NUM_IRQ channels and sequences the two-pulse INTA handshake. It drives the interrupt vector and supports normal EOI, specific EOI, automatic EOI and rotating priority. It sits between the priority resolver, which supplies the winning request, and the data-bus buffer, which receives the vector and ISR readback.

Parameters:
NUM_IRQ, 8, channel count; power of 2, range 2..32
IDX_W, $clog2(NUM_IRQ), channel index width (derived, not overridden)
VEC_W, 8, vector byte width; VEC_W > IDX_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
intReq  in  1  resolver has a pending winning request
intReqIndex  in  IDX_W  index of the winning request
intaPulse  in  1  one-cycle strobe per INTA pulse, already synchronised
vectorBase  in  VEC_W-IDX_W  upper vector bits from ICW2
autoEoi  in  1  AEOI mode from ICW4
eoiValid  in  1  one-cycle EOI command strobe from OCW2 decode
eoiSpecific  in  1  1 = specific EOI, 0 = non-specific EOI
eoiIndex  in  IDX_W  target channel for a specific EOI
eoiRotate  in  1  rotate priority on this EOI or AEOI
readIsr  in  1  request ISR readback onto dataOut
isrValue  out  NUM_IRQ  current ISR contents, to the resolver
lowestPrio  out  IDX_W  current lowest-priority channel
dataOut  out  VEC_W  vector or ISR readback
dataOutValid  out  1  dataOut valid this cycle
resetedIndex  out  IDX_W  channel cleared by the last EOI or AEOI
resetedValid  out  1  one-cycle strobe when a bit is cleared
busy  out  1  handshake between the first and second INTA

Behaviour:
- Reset (synchronous, active-high): isr=0, state=IDLE, lowestPrio=NUM_IRQ-1 (IR0 highest), dataOut=0, dataOutValid=0, resetedIndex=0, resetedValid=0, busy=0.
- Reset mid-handshake aborts it: no vector is driven and no ISR bit stays set.
- FSM states: IDLE, ACK1.
  - IDLE + intaPulse + intReq: latch idx=intReqIndex, set isr[idx] at the next edge, go to ACK1, busy=1.
  - IDLE + intaPulse + !intReq (spurious): latch idx=NUM_IRQ-1, set no ISR bit, go to ACK1.
  - ACK1 + intaPulse: register dataOut={vectorBase, idx}, dataOutValid=1 for one cycle, return to IDLE.
  - ACK1 + intaPulse + autoEoi + non-spurious: clear isr[idx] at the same edge and pulse resetedValid with resetedIndex=idx. If eoiRotate, lowestPrio<=idx.
- Non-specific EOI: scan from (lowestPrio+1) mod NUM_IRQ upward with wrap-around and clear the first set bit. If eoiRotate, lowestPrio<=that index. If ISR=0: no change and resetedValid=0.
- Specific EOI: clear isr[eoiIndex]. Index 0 is valid. If eoiRotate, lowestPrio<=eoiIndex. If the bit is already 0: no ISR change, resetedValid=0, and the rotation still applies.
- Update equation: isr_next=(isr & ~clrMask) | setMask.
  - Clears are computed from the pre-edge ISR.
  - If set and clear hit the same bit in one cycle, set wins.
- EOI and AEOI in the same cycle: AEOI clear and rotation take precedence. The EOI is dropped, with resetedValid reporting the AEOI channel.
- readIsr: dataOut=isr (zero-extended to VEC_W), dataOutValid=1, one cycle latency. A vector drive in the same cycle wins and readIsr is ignored.
- isrValue is a registered output; it reflects updates one cycle after the causing edge.
- Latency: all outputs are registered, 1 cycle after the causing strobe.

Decomposition:
- Shared package pic_pkg:
  - state enum {IDLE, ACK1}
  - IDX_W derivation function
  - SPURIOUS_IDX constant (NUM_IRQ-1)
  - EOI command encodings, shared with the OCW2 decoder
- One natural sub-module, rotating_priority_scan: combinational find-first-set over NUM_IRQ bits starting at (lowestPrio+1) mod NUM_IRQ. Outputs found and index. Reused by the priority resolver.

Test Plan:
- Reset, then intReq=1, intReqIndex=3, vectorBase=5'b01000, two intaPulse 4 cycles apart -> isrValue=8'h08 after the first pulse; dataOut=8'h43 with dataOutValid for 1 cycle after the second; busy high between the pulses.
- ISR=8'h28, lowestPrio=7, non-specific EOI, eoiRotate=0 -> isr=8'h20, resetedIndex=3, resetedValid pulse. Repeat with lowestPrio=4 -> bit 5 is cleared first.
- Specific EOI on index 0 with isr=8'h01, eoiRotate=1 -> isr=0, resetedIndex=0, lowestPrio=0; next scan starts at IR1.
- autoEoi=1, intReqIndex=6, full handshake -> isr[6] set after ACK1 and cleared on ACK2, resetedIndex=6. A simultaneous eoiValid is dropped.
- Spurious: intaPulse with intReq=0 twice -> dataOut={vectorBase,3'b111}, isrValue unchanged.
- reset asserted between the two INTA pulses -> state IDLE, isr=0, no dataOutValid on the later pulse. readIsr then returns 8'h00.
